// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin pick helper for the SDRAM port arbiter.
package sdram_arb_pkg;

    localparam int unsigned MAX_CLIENTS = 8;
    localparam int unsigned PTR_MAX_W   = 3;
    localparam int unsigned DBL_W       = 2 * MAX_CLIENTS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } arb_state_t;

    // One-hot grant: first set bit of req at or above ptr, wrapping modulo n.
    // Rotation uses a doubled vector so the lowest-set-bit trick can do the search.
    function automatic logic [MAX_CLIENTS-1:0] rr_pick(
        input logic [MAX_CLIENTS-1:0] req,
        input logic [PTR_MAX_W-1:0]   ptr,
        input int unsigned            n
    );
        logic [MAX_CLIENTS-1:0] mask;
        logic [MAX_CLIENTS-1:0] rot;
        logic [MAX_CLIENTS-1:0] first;
        logic [DBL_W-1:0]       dbl;
        logic [DBL_W-1:0]       back;
        mask  = MAX_CLIENTS'((DBL_W'(1) << n) - DBL_W'(1));
        dbl   = (DBL_W'(req & mask) << n) | DBL_W'(req & mask);
        rot   = MAX_CLIENTS'(dbl >> ptr) & mask;
        first = rot & (~rot + MAX_CLIENTS'(1));
        back  = DBL_W'(first) << ptr;
        return (MAX_CLIENTS'(back) | MAX_CLIENTS'(back >> n)) & mask;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: rotate by ptr, find first, rotate back.
module rr_priority_pick
    import sdram_arb_pkg::*;
#(
    parameter  int unsigned N_CLIENTS = 4,
    localparam int unsigned PTR_W     = $clog2(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [N_CLIENTS-1:0] gnt,
    output logic                 any
);

    logic [MAX_CLIENTS-1:0] gnt_full;

    always_comb begin
        gnt_full = rr_pick(MAX_CLIENTS'(req), PTR_MAX_W'(ptr), N_CLIENTS);
        gnt      = gnt_full[N_CLIENTS-1:0];
        any      = |gnt_full;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM controller port
// among level-request clients, with a watchdog for a port that never acks.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CLIENTS-1:0]        c_req,
    input  logic [N_CLIENTS-1:0]        c_we,
    input  logic [2*N_CLIENTS-1:0]      c_be,
    input  logic [N_CLIENTS*ADDR_W-1:0] c_addr,
    input  logic [16*N_CLIENTS-1:0]     c_wdata,
    output logic [N_CLIENTS-1:0]        c_ack,
    output logic [15:0]                 c_rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_wrl,
    output logic                        mem_wrh,
    output logic [15:0]                 mem_din,
    input  logic [15:0]                 mem_dout,
    output logic                        mem_req,
    input  logic                        mem_ack,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int unsigned PTR_W = $clog2(N_CLIENTS);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t           state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     gnt;
    logic [N_CLIENTS-1:0] skip;
    logic [WD_W-1:0]      wd;
    logic                 we_q;

    logic [N_CLIENTS-1:0] pick;
    logic                 pick_any;
    logic [PTR_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [15:0]          sel_wdata;
    logic [1:0]           sel_be;
    logic                 sel_we;
    logic [N_CLIENTS-1:0] gnt_onehot;

    rr_priority_pick #(
        .N_CLIENTS(N_CLIENTS)
    ) u_pick (
        .req(c_req & ~skip),
        .ptr(ptr),
        .gnt(pick),
        .any(pick_any)
    );

    always_comb begin
        pick_idx  = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < N_CLIENTS; i++) begin
            if (pick[i]) begin
                pick_idx  = PTR_W'(i);
                sel_addr  = c_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = c_wdata[i*16 +: 16];
                sel_be    = c_be[i*2 +: 2];
                sel_we    = c_we[i];
            end
        end
    end

    assign gnt_onehot = N_CLIENTS'(1) << gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            gnt         <= '0;
            skip        <= '0;
            wd          <= '0;
            we_q        <= 1'b0;
            c_ack       <= '0;
            c_rdata     <= '0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_wrl     <= 1'b0;
            mem_wrh     <= 1'b0;
            // Match the ack line so an access in flight is not re-requested.
            mem_req     <= mem_ack;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    skip <= '0;
                    if (pick_any) begin
                        gnt      <= pick_idx;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_wdata;
                        mem_wrl  <= sel_we & sel_be[0];
                        mem_wrh  <= sel_we & sel_be[1];
                        we_q     <= sel_we;
                        mem_req  <= ~mem_req;
                        wd       <= '0;
                        busy     <= 1'b1;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ack == mem_req) begin
                        if (!we_q) c_rdata <= mem_dout;
                        c_ack <= gnt_onehot;
                        state <= S_DONE;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        c_rdata     <= '1;
                        c_ack       <= gnt_onehot;
                        mem_req     <= mem_ack;
                        state       <= S_DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_DONE: begin
                    c_ack <= '0;
                    ptr   <= (gnt == PTR_W'(N_CLIENTS - 1)) ? '0 : gnt + PTR_W'(1);
                    // Served client still holds c_req for one more cycle.
                    skip  <= gnt_onehot;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: client agents, a toggle-handshake controller
// model, a transaction-rule reference model and directed scenarios.
module tb_sdram_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 24;
    localparam int unsigned TO = 1023;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      c_req = '0;
    logic [N-1:0]      c_we = '0;
    logic [2*N-1:0]    c_be = '0;
    logic [N*AW-1:0]   c_addr = '0;
    logic [16*N-1:0]   c_wdata = '0;
    logic [N-1:0]      c_ack;
    logic [15:0]       c_rdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_wrl, mem_wrh;
    logic [15:0]       mem_din;
    logic [15:0]       mem_dout = '0;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic              busy, timeout_err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .N_CLIENTS(N),
        .ADDR_W(AW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .mem_addr(mem_addr), .mem_wrl(mem_wrl), .mem_wrh(mem_wrh), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_req(mem_req), .mem_ack(mem_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- controller model ----------------
    logic [15:0] mem [int];
    int unsigned lat   = 6;
    bit          noack = 1'b0;
    bit          pend  = 1'b0;
    int unsigned cnt   = 0;
    int          starts = 0;
    logic [AW-1:0] p_addr;
    logic          p_wl, p_wh;
    logic [15:0]   p_din;

    function automatic logic [15:0] memrd(input int a);
        if (mem.exists(a)) return mem[a];
        if (a == 32'h1234) return 16'hBEEF;
        return a[15:0] ^ 16'h3C3C;
    endfunction

    initial forever begin
        logic [15:0] v;
        @(negedge clk);
        if (pend && mem_req == mem_ack) begin
            pend = 1'b0;
        end else if (!pend && mem_req != mem_ack) begin
            pend = 1'b1; cnt = lat; starts++;
            p_addr = mem_addr; p_wl = mem_wrl; p_wh = mem_wrh; p_din = mem_din;
        end
        if (pend && !noack) begin
            if (cnt <= 1) begin
                v = memrd(int'(p_addr));
                if (p_wl) v[7:0]  = p_din[7:0];
                if (p_wh) v[15:8] = p_din[15:8];
                if (p_wl || p_wh) begin
                    mem[int'(p_addr)] = v;
                    mem_dout = 16'hDEAD;
                end else begin
                    mem_dout = v;
                end
                mem_ack = mem_req;
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
    end

    // ---------------- client agents ----------------
    logic          job_we   [N] = '{default: 1'b0};
    logic [1:0]    job_be   [N] = '{default: 2'b11};
    logic [AW-1:0] job_addr [N] = '{default: '0};
    logic [15:0]   job_data [N] = '{default: '0};
    int            job_gap  [N] = '{default: 0};
    int            job_total[N] = '{default: 0};
    int            acked    [N] = '{default: 0};
    int            st       [N] = '{default: 0};
    int            hcnt     [N] = '{default: 0};

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (reset) begin
                c_req[i] = 1'b0; st[i] = 0; acked[i] = job_total[i];
            end else begin
                case (st[i])
                    0: if (acked[i] < job_total[i]) begin
                        c_we[i] = job_we[i];
                        c_be[2*i +: 2] = job_be[i];
                        c_addr[i*AW +: AW] = job_addr[i];
                        c_wdata[i*16 +: 16] = job_data[i];
                        c_req[i] = 1'b1;
                        st[i] = 1;
                    end
                    1: if (c_ack[i]) begin
                        acked[i]++; hcnt[i] = 1; st[i] = 2;
                    end
                    2: if (hcnt[i] == 0) begin
                        c_req[i] = 1'b0;
                        c_addr[i*AW +: AW] = AW'($urandom);
                        c_wdata[i*16 +: 16] = 16'($urandom);
                        hcnt[i] = job_gap[i]; st[i] = 3;
                    end else hcnt[i]--;
                    3: if (hcnt[i] == 0) st[i] = 0; else hcnt[i]--;
                    default: st[i] = 0;
                endcase
            end
        end
    end

    // ---------------- reference model (rule level) ----------------
    int            ph = 0;
    int            m_ptr = 0, m_gnt = 0, m_wd = 0;
    logic [N-1:0]  m_skip = '0;
    logic          m_we = 1'b0;
    bit            m_started = 1'b0;
    logic [N-1:0]  e_ack = '0;
    logic [15:0]   e_rdata = '0, e_din = '0;
    logic [AW-1:0] e_addr = '0;
    logic          e_wrl = 1'b0, e_wrh = 1'b0, e_req = 1'b0, e_busy = 1'b0, e_terr = 1'b0;
    int            glog[$];
    int            acc_cnt[N] = '{default: 0};

    initial forever begin
        logic [N-1:0] cand;
        bit found;
        int c;
        @(posedge clk);
        if (reset) begin
            ph = 0; m_ptr = 0; m_gnt = 0; m_skip = '0; m_we = 1'b0;
            e_ack = '0; e_rdata = '0; e_din = '0; e_addr = '0;
            e_wrl = 1'b0; e_wrh = 1'b0; e_busy = 1'b0; e_terr = 1'b0;
            e_req = mem_ack; m_started = 1'b1;
        end else if (ph == 0) begin
            cand = c_req & ~m_skip;
            m_skip = '0;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && cand[c]) begin
                    found = 1'b1;
                    m_gnt = c;
                    e_addr = c_addr[c*AW +: AW];
                    e_din = c_wdata[c*16 +: 16];
                    m_we = c_we[c];
                    e_wrl = m_we & c_be[2*c];
                    e_wrh = m_we & c_be[2*c+1];
                    e_req = ~e_req; m_wd = 0; e_busy = 1'b1; ph = 1;
                    glog.push_back(c); acc_cnt[c]++;
                end
            end
        end else if (ph == 1) begin
            if (mem_ack == e_req) begin
                if (!m_we) e_rdata = mem_dout;
                e_ack = N'(1) << m_gnt; ph = 2;
            end else begin
                m_wd++;
                if (m_wd == TO) begin
                    e_terr = 1'b1; e_rdata = 16'hFFFF;
                    e_ack = N'(1) << m_gnt; e_req = mem_ack; ph = 2;
                end
            end
        end else begin
            e_ack = '0; m_ptr = (m_gnt + 1) % N; m_skip = N'(1) << m_gnt;
            e_busy = 1'b0; ph = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    int          ack_cnt[N] = '{default: 0};
    logic [N-1:0] last_ack_vec = '0;
    logic [15:0] last_ack_rdata = '0;
    int          busy_cycles = 0;

    initial forever begin
        @(negedge clk);
        if (m_started) begin
            chk("c_ack", 32'(c_ack), 32'(e_ack));
            chk("c_rdata", 32'(c_rdata), 32'(e_rdata));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_din", 32'(mem_din), 32'(e_din));
            chk("mem_wrl", 32'(mem_wrl), 32'(e_wrl));
            chk("mem_wrh", 32'(mem_wrh), 32'(e_wrh));
            chk("mem_req", 32'(mem_req), 32'(e_req));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("timeout_err", 32'(timeout_err), 32'(e_terr));
        end
        if (c_ack != '0) begin
            last_ack_vec = c_ack; last_ack_rdata = c_rdata;
        end
        for (int i = 0; i < N; i++) if (c_ack[i]) ack_cnt[i]++;
        if (busy) busy_cycles++;
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_jobs(input int limit);
        bit done;
        done = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < N; i++) if (acked[i] < job_total[i]) done = 1'b0;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL jobs_done: got pending expected all acked at %0t", $time);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic set_job(input int i, input logic we, input logic [1:0] be,
                           input logic [AW-1:0] a, input logic [15:0] d, input int gap, input int n);
        job_we[i] = we; job_be[i] = be; job_addr[i] = a; job_data[i] = d;
        job_gap[i] = gap; job_total[i] += n;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #3 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0, a0, g0, b0, w;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("rst_c_ack", 32'(c_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_eq_ack", 32'(mem_req), 32'(mem_ack));

        // single read
        lat = 6; s0 = starts; a0 = ack_cnt[2];
        set_job(2, 1'b0, 2'b11, 24'h001234, 16'h0000, 0, 1);
        wait_jobs(200);
        chk("read_toggles", 32'(starts - s0), 1);
        chk("read_ack_cycles", 32'(ack_cnt[2] - a0), 1);
        chk("read_ack_vec", 32'(last_ack_vec), 32'h4);
        chk("read_rdata", 32'(last_ack_rdata), 32'hBEEF);

        // high-byte write
        set_job(0, 1'b1, 2'b10, 24'h000010, 16'h5A00, 0, 1);
        wait_jobs(200);
        chk("wr_wrh", 32'(mem_wrh), 1);
        chk("wr_wrl", 32'(mem_wrl), 0);
        chk("wr_din", 32'(mem_din), 32'h5A00);
        chk("wr_addr", 32'(mem_addr), 32'h10);
        chk("wr_rdata_kept", 32'(c_rdata), 32'hBEEF);

        // read back the merged word
        set_job(1, 1'b0, 2'b11, 24'h000010, 16'h0000, 0, 1);
        wait_jobs(200);
        chk("readback", 32'(last_ack_rdata), 32'h5A2C);

        // contention: ptr is 2 after the three accesses above
        lat = 4; g0 = glog.size();
        @(posedge clk);
        for (int i = 0; i < N; i++) set_job(i, 1'b0, 2'b11, AW'(24'h000100 + i), 16'h0000, 0, 3);
        wait_jobs(600);
        chk("cont_count", 32'(glog.size() - g0), 12);
        for (int k = 0; k < 12 && g0 + k < glog.size(); k++)
            chk("cont_order", 32'(glog[g0+k]), 32'((2 + k) % 4));

        // re-grant guard
        s0 = starts; a0 = ack_cnt[1];
        set_job(1, 1'b0, 2'b11, 24'h000321, 16'h0000, 1, 4);
        wait_jobs(400);
        chk("regrant_toggles", 32'(starts - s0), 4);
        chk("regrant_acks", 32'(ack_cnt[1] - a0), 4);

        // watchdog
        noack = 1'b1; b0 = busy_cycles;
        set_job(3, 1'b0, 2'b11, 24'h000777, 16'h0000, 0, 1);
        wait_jobs(1300);
        chk("wd_err", 32'(timeout_err), 1);
        chk("wd_rdata", 32'(last_ack_rdata), 32'hFFFF);
        chk("wd_ack_vec", 32'(last_ack_vec), 32'h8);
        chk("wd_req_eq_ack", 32'(mem_req), 32'(mem_ack));
        chk("wd_busy_cycles", 32'(busy_cycles - b0), 1024);
        noack = 1'b0;
        set_job(3, 1'b0, 2'b11, 24'h000777, 16'h0000, 0, 1);
        wait_jobs(200);
        chk("wd_after_rdata", 32'(last_ack_rdata), 32'h3B4B);
        chk("wd_sticky", 32'(timeout_err), 1);

        // reset during WAIT
        lat = 20; a0 = ack_cnt[2];
        set_job(2, 1'b0, 2'b11, 24'h000200, 16'h0000, 0, 1);
        w = 0;
        while (!busy && w < 30) begin @(negedge clk); w++; end
        chk("rw_entered_wait", 32'(busy), 1);
        repeat (3) @(negedge clk);
        pulse_reset();
        chk("rw_c_ack", 32'(c_ack), 0);
        chk("rw_busy", 32'(busy), 0);
        chk("rw_req_eq_ack", 32'(mem_req), 32'(mem_ack));
        chk("rw_addr", 32'(mem_addr), 0);
        chk("rw_rdata", 32'(c_rdata), 0);
        chk("rw_terr", 32'(timeout_err), 0);
        repeat (40) @(negedge clk);
        chk("rw_no_ack", 32'(ack_cnt[2] - a0), 0);

        // normal access after reset
        lat = 3;
        set_job(0, 1'b0, 2'b11, 24'h001234, 16'h0000, 0, 1);
        wait_jobs(200);
        chk("post_rst_rdata", 32'(last_ack_rdata), 32'hBEEF);
        chk("post_rst_vec", 32'(last_ack_vec), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        total++; bad++;
        $display("FAIL global_time_limit: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
